// File: rtl/pwm_gen_pkg.sv
// pwm_gen_pkg: FSM state type and duty clamp helper shared by pwm_gen.
package pwm_gen_pkg;

    typedef enum logic [1:0] {IDLE, ARMED, RUN} pwm_state_e;

    // Requests above a full period saturate to 100%
    function automatic logic [31:0] clamp_duty(input logic [31:0] d, input int unsigned w);
        return (d > (32'd1 << w)) ? (32'd1 << w) : d;
    endfunction

endpackage

// File: rtl/pwm_wrap_det.sv
// pwm_wrap_det: registers the upstream counter and flags a wrap whenever it steps backwards.
module pwm_wrap_det #(
    parameter int CNTR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [CNTR_WIDTH-1:0] cntr,
    output logic                  wrap
);

    logic [CNTR_WIDTH-1:0] cntr_q;

    always_ff @(posedge clk or posedge rst)
        if (rst) cntr_q <= '0;
        else     cntr_q <= cntr;

    // Covers both natural rollover and an upstream counter reset
    assign wrap = cntr < cntr_q;

endmodule

// File: rtl/pwm_gen.sv
// pwm_gen: PWM generator slaved to an upstream counter, duty updates applied at period boundaries.
// Define PWM_GEN_COMPL_EN to add the complementary output pwm_n_o.
module pwm_gen
    import pwm_gen_pkg::*;
#(
    parameter int CNTR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [CNTR_WIDTH-1:0] cntr,
    input  logic                  en,
    input  logic [CNTR_WIDTH:0]   duty,
    input  logic                  duty_valid,
    output logic                  duty_ready,
    output logic                  pwm_o,
    output logic                  period_start_o
`ifdef PWM_GEN_COMPL_EN
    ,
    output logic                  pwm_n_o
`endif
);

    localparam int DW = CNTR_WIDTH + 1;

    pwm_state_e    state, state_n;
    logic          wrap, pend_vld, live, on_d, hit;
    logic [DW-1:0] pending, active_duty, eff_duty;

    pwm_wrap_det #(.CNTR_WIDTH(CNTR_WIDTH)) u_wrap (
        .clk  (clk),
        .rst  (rst),
        .cntr (cntr),
        .wrap (wrap)
    );

    assign duty_ready = !pend_vld;
    assign live       = state != IDLE;
    // A duty swapping in at this wrap already governs the first sample of the new period
    assign eff_duty   = (wrap && pend_vld) ? pending : active_duty;
    assign hit        = {1'b0, cntr} < eff_duty;
    assign on_d       = en && (state == RUN || (state == ARMED && wrap));

    always_ff @(posedge clk or posedge rst)
        if (rst) state <= IDLE;
        else     state <= state_n;

    always_comb begin
        state_n = !en                      ? IDLE  :
                  state == IDLE            ? ARMED :
                  (state == ARMED && wrap) ? RUN   : state;
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            pending     <= '0;
            pend_vld    <= 1'b0;
            active_duty <= '0;
        end else if (live && wrap && pend_vld) begin
            active_duty <= pending;
            pend_vld    <= 1'b0;
        end else if (duty_valid && !pend_vld) begin
            pending  <= DW'(clamp_duty(32'(duty), CNTR_WIDTH));
            pend_vld <= 1'b1;
        end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            pwm_o          <= 1'b0;
            period_start_o <= 1'b0;
        end else begin
            pwm_o          <= on_d && hit;
            period_start_o <= live && wrap;
        end

`ifdef PWM_GEN_COMPL_EN
    always_ff @(posedge clk or posedge rst)
        if (rst) pwm_n_o <= 1'b0;
        else     pwm_n_o <= on_d && !hit;
`endif

endmodule

// File: tb/tb_pwm_gen.sv
// tb_pwm_gen: randomized and directed checks of pwm_gen against an in-bench period model.
module tb_pwm_gen;

    localparam int W    = 4;
    localparam int FULL = 1 << W;

    logic         clk = 1'b0;
    logic         rst, en, duty_valid, duty_ready, pwm_o, period_start_o;
    logic [W-1:0] cntr;
    logic [W:0]   duty;

    int checks = 0, errors = 0;
    int c = 0;
    int m_prev, m_mode, m_act, m_pend;
    bit m_has, e_pwm, e_ps;

    pwm_gen #(.CNTR_WIDTH(W)) dut (
        .clk            (clk),
        .rst            (rst),
        .cntr           (cntr),
        .en             (en),
        .duty           (duty),
        .duty_valid     (duty_valid),
        .duty_ready     (duty_ready),
        .pwm_o          (pwm_o),
        .period_start_o (period_start_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic model_reset();
        m_prev = 0; m_mode = 0; m_act = 0; m_pend = 0; m_has = 0; e_pwm = 0; e_ps = 0;
    endtask

    // Mode: 0 off, 1 waiting for a period boundary, 2 running
    task automatic step(input bit r, input int cn, input bit e, input bit dv, input int d);
        bit wrap;
        int eff;
        rst = r; cntr = W'(cn); en = e; duty_valid = dv; duty = (W+1)'(d);
        if (r) model_reset();
        else begin
            wrap  = cn < m_prev;
            eff   = (wrap && m_has) ? m_pend : m_act;
            e_pwm = e && (m_mode == 2 || (m_mode == 1 && wrap)) && cn < eff;
            e_ps  = m_mode != 0 && wrap;
            if (m_mode != 0 && wrap && m_has) begin
                m_act = m_pend;
                m_has = 0;
            end else if (dv && !m_has) begin
                m_pend = d > FULL ? FULL : d;
                m_has  = 1;
            end
            m_mode = !e ? 0 : m_mode == 0 ? 1 : (m_mode == 1 && wrap) ? 2 : m_mode;
            m_prev = cn;
        end
        @(posedge clk);
        @(negedge clk);
        chk("pwm_o", pwm_o, e_pwm);
        chk("period_start_o", period_start_o, e_ps);
        chk("duty_ready", duty_ready, !m_has);
    endtask

    task automatic tick(input bit e, input bit dv, input int d);
        step(0, c, e, dv, d);
        c = (c + 1) % FULL;
    endtask

    task automatic window(input string name, input int exp_hi, input int exp_ps);
        int hi = 0, ps = 0;
        repeat (FULL) begin
            tick(1, 0, 0);
            hi += int'(pwm_o);
            ps += int'(period_start_o);
        end
        chk({name, "_high"}, hi, exp_hi);
        chk({name, "_pulses"}, ps, exp_ps);
    endtask

    initial begin
        int hi;
        bit rdy_seen;
        rst = 1; en = 0; duty_valid = 0; duty = '0; cntr = '0;
        model_reset();
        @(negedge clk);
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        chk("reset_pwm", pwm_o, 0);
        chk("reset_ready", duty_ready, 1);
        chk("reset_ps", period_start_o, 0);

        tick(0, 1, 8);
        chk("idle_accept_ready", duty_ready, 0);
        repeat (20) tick(1, 0, 0);
        window("duty8", 8, 1);

        tick(1, 1, 0);  repeat (40) tick(1, 0, 0); window("duty0", 0, 1);
        tick(1, 1, 16); repeat (40) tick(1, 0, 0); window("duty16", 16, 1);
        tick(1, 1, 20); repeat (40) tick(1, 0, 0); window("duty20", 16, 1);
        tick(1, 1, 4);  repeat (40) tick(1, 0, 0);

        // Mid-period reload: the current period keeps duty 4, a held request waits for ready
        while (c != 6) tick(1, 0, 0);
        tick(1, 1, 12);
        chk("midload_ready", duty_ready, 0);
        hi = int'(pwm_o);
        rdy_seen = 0;
        while (c != 0) begin
            tick(1, 1, 2);
            hi += int'(pwm_o);
            rdy_seen |= duty_ready;
        end
        chk("midload_tail_high", hi, 0);
        chk("midload_ready_held", rdy_seen, 0);
        tick(1, 1, 2);
        hi = int'(pwm_o);
        chk("wrap_ready", duty_ready, 1);
        tick(1, 1, 2);
        hi += int'(pwm_o);
        chk("held_accept_ready", duty_ready, 0);
        while (c != 0) begin
            tick(1, 0, 0);
            hi += int'(pwm_o);
        end
        chk("reload_high", hi, 12);

        while (c != 9) tick(1, 0, 0);
        tick(1, 0, 0);
        c = 0;
        tick(1, 0, 0);
        chk("upstream_reset_ps", period_start_o, 1);
        chk("upstream_reset_pwm", pwm_o, 1);
        c = 1;
        repeat (15) tick(1, 0, 0);
        window("duty2", 2, 1);

        // Asynchronous reset in the middle of a high stretch
        tick(1, 1, 16);
        repeat (40) tick(1, 0, 0);
        while (c != 5) tick(1, 0, 0);
        tick(1, 0, 0);
        chk("pre_rst_pwm", pwm_o, 1);
        tick(1, 1, 3);
        chk("pre_rst_ready", duty_ready, 0);
        #2 rst = 1;
        #1;
        chk("async_rst_pwm", pwm_o, 0);
        chk("async_rst_ready", duty_ready, 1);
        model_reset();
        @(negedge clk);
        step(1, c, 0, 0, 0);
        repeat (40) tick(1, 0, 0);
        window("post_rst", 0, 1);

        repeat (3000) begin
            bit r, e, dv;
            int d;
            r  = $urandom_range(199) == 0;
            e  = $urandom_range(9) != 0;
            dv = $urandom_range(2) == 0;
            d  = $urandom_range(20);
            if ($urandom_range(29) == 0) c = 0;
            step(r, c, e, dv, d);
            c = (c + 1) % FULL;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pwm_gen.md
PWM_GEN -- requirements
Module: pwm_gen

Interface
REQ-001 SHALL have parameter CNTR_WIDTH, default 4, the width of the upstream counter value.
REQ-002 SHALL have port clk, input, 1 bit, the single clock; all logic is rising-edge.
REQ-003 SHALL have port rst, input, 1 bit, the asynchronous, active-high reset.
REQ-004 SHALL have port cntr, input, CNTR_WIDTH bits, the free-running value from the upstream counter, synchronous to clk.
REQ-005 SHALL have port en, input, 1 bit, the PWM enable (level).
REQ-006 SHALL have port duty, input, CNTR_WIDTH+1 bits, the requested high-count per period.
REQ-007 SHALL have port duty_valid, input, 1 bit, which qualifies duty.
REQ-008 SHALL have port duty_ready, output, 1 bit, high when the pending slot is empty.
REQ-009 SHALL have port pwm_o, output, 1 bit, the registered PWM waveform.
REQ-010 SHALL have port period_start_o, output, 1 bit, a one-cycle pulse marking a new period.

Function
REQ-011 SHALL register cntr into cntr_q every cycle; wrap = (cntr < cntr_q), combinational, which covers both natural rollover and an upstream counter reset.
REQ-012 SHALL accept duty on the cycle (duty_valid && duty_ready) into a pending register and set pend_vld; duty_ready = !pend_vld.
REQ-013 SHALL clamp accepted duty values above 2^CNTR_WIDTH to 2^CNTR_WIDTH (100%).
REQ-014 SHALL implement an FSM with states IDLE, ARMED and RUN.
- IDLE: en=1 -> ARMED.
- ARMED: wrap -> RUN; en=0 -> IDLE.
- RUN: en=0 -> IDLE.
- en=0 takes priority over wrap.
REQ-015 SHALL, on wrap in ARMED or RUN with pend_vld=1, copy pending to active_duty and clear pend_vld in the same edge.
REQ-016 SHALL, for simultaneous accept and wrap (possible only when pend_vld=0), leave active_duty unchanged; the new value applies at the next wrap.
REQ-017 SHALL, in RUN, set pwm_o <= (cntr < eff_duty). eff_duty = pending if (wrap && pend_vld), else active_duty. Latency is 1 cycle from cntr.
REQ-018 SHALL, on the ARMED->RUN edge, set pwm_o <= (cntr < eff_duty), so the first period starts high when duty is nonzero.
REQ-019 SHALL drive pwm_o low in IDLE and ARMED; when en falls, pwm_o SHALL be 0 one cycle later.
REQ-020 SHALL hold pwm_o constant low for duty 0 and constant high in RUN for duty 2^CNTR_WIDTH.
REQ-021 SHALL pulse period_start_o high for exactly one cycle, the cycle after a wrap seen in ARMED or RUN (not IDLE).
REQ-022 SHALL retain active_duty and pending across en deassertion.

Reset
REQ-023 SHALL, on rst high, asynchronously force the following; duty_ready SHALL therefore read 1 during and after reset.
- state=IDLE
- cntr_q=0, active_duty=0, pending=0, pend_vld=0
- pwm_o=0, period_start_o=0
REQ-024 SHALL, on rst asserted mid-period, drop pwm_o immediately and discard any pending duty.

Configuration
REQ-025 SHALL, when macro PWM_GEN_COMPL_EN is defined, add output pwm_n_o, 1 bit: registered !pwm_o-equivalent in RUN, 0 in IDLE/ARMED and in reset.
REQ-026 SHALL, without PWM_GEN_COMPL_EN, have no pwm_n_o port and no associated logic.

Structure
REQ-027 SHALL place the following in a package pwm_gen_pkg:
- state enum pwm_state_e {IDLE, ARMED, RUN}
- the duty clamp function
REQ-028 SHALL contain one sub-module pwm_wrap_det that registers cntr_q and produces wrap.

Verification (CNTR_WIDTH=4, upstream counter 0..15, driven by the existing counter block)
REQ-029 SHALL cover: duty=8 loaded in IDLE, en=1 -> first wrap enters RUN; pwm_o is high 8 cycles, low 8 cycles, repeating; period_start_o pulses every 16 cycles.
REQ-030 SHALL cover: duty=0 and duty=16 -> pwm_o constant 0 and constant 1 respectively in RUN; duty=20 behaves as 16.
REQ-031 SHALL cover: in RUN at duty=4, load duty=12 mid-period -> current period stays 4 high; next period is 12 high; duty_ready is low from accept to wrap.
REQ-032 SHALL cover: duty_valid held with a new value while pend_vld=1 -> not accepted until duty_ready=1.
REQ-033 SHALL cover: upstream counter reset to 0 at cntr=9 -> wrap detected, period_start_o pulses, and a new period begins.
REQ-034 SHALL cover: rst asserted at cntr=5 in RUN -> pwm_o=0 asynchronously; after release, state=IDLE, duty_ready=1, active_duty=0.
